boid_frame_drawer: RTL

- Reader end of the boid state memory: once per frame, walks every boid slot, reads its fixed-point position and emits pixel writes toward the VGA framebuffer writer.
- Two passes per frame: erase the previously drawn pixels (background colour), then draw the current positions (foreground colour).
- Sits between the boid memory wrapper (read-only use of which_boid / x / y) and the M10k framebuffer write port.
- Drives mem_rd_en so the top-level arbiter blocks the update engine from writing during a read.

---
 rtl/boid_draw_pkg.sv | 25 ++
 rtl/boid_fix_to_pixel.sv | 29 ++
 rtl/boid_frame_drawer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/boid_draw_pkg.sv
// Shared types and widths for the boid frame drawer and the fixed-point to pixel helper.
package boid_draw_pkg;

    localparam int unsigned FRAC_BITS = 16;
    localparam int unsigned X_W       = 28;
    localparam int unsigned Y_W       = 27;
    localparam int unsigned PIX_X_W   = 10;
    localparam int unsigned PIX_Y_W   = 9;
    localparam int unsigned COLOR_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        READ,
        DRAW,
        DONE
    } state_t;

    typedef struct packed {
        logic [PIX_X_W-1:0] x;
        logic [PIX_Y_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pix_t;

endpackage

// File: rtl/boid_fix_to_pixel.sv
// Truncates signed fixed-point boid coordinates to integer pixels and flags on-screen ones.
module boid_fix_to_pixel
    import boid_draw_pkg::*;
#(
    parameter int unsigned frac_bits = FRAC_BITS,
    parameter int unsigned screen_w  = 640,
    parameter int unsigned screen_h  = 480
) (
    input  logic [X_W-1:0]           x,
    input  logic [Y_W-1:0]           y,
    output logic [X_W-frac_bits-1:0] xi,
    output logic [Y_W-frac_bits-1:0] yi,
    output logic                     visible
);

    localparam int unsigned XI_W = X_W - frac_bits;
    localparam int unsigned YI_W = Y_W - frac_bits;

    logic unused_frac;

    // Dropping the fraction bits is an arithmetic shift with truncation toward -inf.
    assign xi          = x[X_W-1:frac_bits];
    assign yi          = y[Y_W-1:frac_bits];
    assign unused_frac = ^{x[frac_bits-1:0], y[frac_bits-1:0]};

    assign visible = !xi[XI_W-1] && (xi < XI_W'(screen_w))
                  && !yi[YI_W-1] && (yi < YI_W'(screen_h));

endmodule

// File: rtl/boid_frame_drawer.sv
// Per-frame boid renderer: erases last frame's pixels, then reads each boid and draws it.
module boid_frame_drawer
    import boid_draw_pkg::*;
#(
    parameter int unsigned num_boids = 2,
    parameter int unsigned screen_w  = 640,
    parameter int unsigned screen_h  = 480,
    parameter int unsigned frac_bits = FRAC_BITS,
    localparam int unsigned IDX_W    = (num_boids > 1) ? $clog2(num_boids) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   which_boid,
    output logic               mem_rd_en,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic [COLOR_W-1:0] fg_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIX_X_W-1:0] pix_x,
    output logic [PIX_Y_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color
);

    localparam int unsigned XI_W = X_W - frac_bits;
    localparam int unsigned YI_W = Y_W - frac_bits;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_boids - 1);

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt, idx_inc, which_boid_nxt;
    logic [COLOR_W-1:0]   bg, bg_nxt, fg, fg_nxt;
    logic                 busy_nxt, done_nxt, mem_rd_en_nxt, pix_valid_nxt;
    pix_t                 pix, pix_nxt;
    logic [PIX_X_W-1:0]   prev_x     [num_boids];
    logic [PIX_X_W-1:0]   prev_x_nxt [num_boids];
    logic [PIX_Y_W-1:0]   prev_y     [num_boids];
    logic [PIX_Y_W-1:0]   prev_y_nxt [num_boids];
    logic [num_boids-1:0] prev_valid, prev_valid_nxt;
    logic [XI_W-1:0]      xi;
    logic [YI_W-1:0]      yi;
    logic                 visible;
    logic                 xfer;
    logic                 unused_hi;

    boid_fix_to_pixel #(
        .frac_bits (frac_bits),
        .screen_w  (screen_w),
        .screen_h  (screen_h)
    ) u_fix_to_pixel (
        .x       (x_in),
        .y       (y_in),
        .xi      (xi),
        .yi      (yi),
        .visible (visible)
    );

    assign xfer      = pix_valid && pix_ready;
    assign idx_inc   = idx + IDX_W'(1);
    assign unused_hi = ^{xi[XI_W-1:PIX_X_W], yi[YI_W-1:PIX_Y_W]};
    assign pix_x     = pix.x;
    assign pix_y     = pix.y;
    assign pix_color = pix.color;

    // State, output and shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            bg         <= '0;
            fg         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            which_boid <= '0;
            mem_rd_en  <= 1'b0;
            pix_valid  <= 1'b0;
            pix        <= '0;
            prev_valid <= '0;
            for (int i = 0; i < int'(num_boids); i++) begin
                prev_x[i] <= '0;
                prev_y[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            bg         <= bg_nxt;
            fg         <= fg_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            which_boid <= which_boid_nxt;
            mem_rd_en  <= mem_rd_en_nxt;
            pix_valid  <= pix_valid_nxt;
            pix        <= pix_nxt;
            prev_valid <= prev_valid_nxt;
            prev_x     <= prev_x_nxt;
            prev_y     <= prev_y_nxt;
        end
    end

    // Next-state logic; outputs are prepared one cycle ahead so they leave the block registered.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        bg_nxt         = bg;
        fg_nxt         = fg;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        which_boid_nxt = '0;
        mem_rd_en_nxt  = 1'b0;
        pix_valid_nxt  = pix_valid;
        pix_nxt        = pix;
        prev_valid_nxt = prev_valid;
        prev_x_nxt     = prev_x;
        prev_y_nxt     = prev_y;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = ERASE;
                    busy_nxt      = 1'b1;
                    idx_nxt       = '0;
                    bg_nxt        = bg_color;
                    fg_nxt        = fg_color;
                    pix_valid_nxt = prev_valid[0];
                    pix_nxt.x     = prev_x[0];
                    pix_nxt.y     = prev_y[0];
                    pix_nxt.color = bg_color;
                end
            end
            ERASE: begin
                if (!pix_valid || xfer) begin
                    prev_valid_nxt[idx] = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_nxt      = READ;
                        idx_nxt        = '0;
                        pix_valid_nxt  = 1'b0;
                        which_boid_nxt = '0;
                        mem_rd_en_nxt  = 1'b1;
                    end else begin
                        idx_nxt       = idx_inc;
                        pix_valid_nxt = prev_valid[idx_inc];
                        pix_nxt.x     = prev_x[idx_inc];
                        pix_nxt.y     = prev_y[idx_inc];
                        pix_nxt.color = bg;
                    end
                end
            end
            READ: begin
                // Memory data is valid this cycle; capture the converted pixel directly.
                state_nxt     = DRAW;
                pix_valid_nxt = visible;
                pix_nxt.x     = xi[PIX_X_W-1:0];
                pix_nxt.y     = yi[PIX_Y_W-1:0];
                pix_nxt.color = fg;
            end
            DRAW: begin
                if (!pix_valid || xfer) begin
                    prev_valid_nxt[idx] = pix_valid;
                    if (pix_valid) begin
                        prev_x_nxt[idx] = pix.x;
                        prev_y_nxt[idx] = pix.y;
                    end
                    pix_valid_nxt = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt      = READ;
                        idx_nxt        = idx_inc;
                        which_boid_nxt = idx_inc;
                        mem_rd_en_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                idx_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
